// File: rtl/matrix_pkg.sv
// Shared constants and state type for the matrix result reader and operand writer.
package matrix_pkg;
    localparam int N        = 5;
    localparam int W        = 8;
    localparam int MAT_BITS = N * N * W;
    localparam int IDX_W    = 3;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;
endpackage

// File: rtl/matrix_elem_sel.sv
// Combinational extract of element (row,col) from a packed matrix, element (0,0) in the MSBs.
module matrix_elem_sel #(
    parameter int N = matrix_pkg::N,
    parameter int W = matrix_pkg::W
) (
    input  logic [N*N*W-1:0]            vec,
    input  logic [matrix_pkg::IDX_W-1:0] row,
    input  logic [matrix_pkg::IDX_W-1:0] col,
    output logic [W-1:0]                elem
);
    import matrix_pkg::*;

    always_comb begin
        elem = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (row == IDX_W'(r) && col == IDX_W'(c))
                    elem = vec[N*N*W-1-(r*N+c)*W -: W];
            end
        end
    end
endmodule

// File: rtl/matrix_result_reader.sv
// Streams a packed N x N result matrix out one element per valid/ready transfer.
// Optional MATRIX_READER_TRANSPOSE_EN adds a 'transpose' input selecting column-major order.
module matrix_result_reader #(
    parameter int N = matrix_pkg::N,
    parameter int W = matrix_pkg::W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [N*N*W-1:0]             load_data,
    input  logic                         load_ovf,
`ifdef MATRIX_READER_TRANSPOSE_EN
    input  logic                         transpose,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [matrix_pkg::IDX_W-1:0] out_row,
    output logic [matrix_pkg::IDX_W-1:0] out_col,
    output logic                         out_last,
    output logic                         out_ovf,
    output logic                         busy
);
    import matrix_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    rd_state_t          state;
    logic               rdy_en;
    logic [N*N*W-1:0]   shadow;
    logic [N*N*W-1:0]   sel_vec;
    logic [W-1:0]       sel_elem;
    logic [IDX_W-1:0]   nrow, ncol;
    logic               xfer, capture, col_mode;

`ifdef MATRIX_READER_TRANSPOSE_EN
    logic col_major;
    assign col_mode = capture ? transpose : col_major;
`else
    assign col_mode = 1'b0;
`endif

    // rdy_en keeps load_ready low for the first cycle after reset.
    assign load_ready = rdy_en && (state == RD_IDLE || (out_last && out_ready));
    assign capture    = load_valid && load_ready;
    assign xfer       = out_valid && out_ready;

    // A fresh capture reads the incoming bus directly so the first element is ready next cycle.
    assign sel_vec = capture ? load_data : shadow;

    always_comb begin
        nrow = '0;
        ncol = '0;
        if (!capture) begin
            if (col_mode) begin
                if (out_row == LAST) begin
                    nrow = '0;
                    ncol = out_col + IDX_W'(1);
                end else begin
                    nrow = out_row + IDX_W'(1);
                    ncol = out_col;
                end
            end else begin
                if (out_col == LAST) begin
                    ncol = '0;
                    nrow = out_row + IDX_W'(1);
                end else begin
                    ncol = out_col + IDX_W'(1);
                    nrow = out_row;
                end
            end
        end
    end

    matrix_elem_sel #(.N(N), .W(W)) u_sel (
        .vec  (sel_vec),
        .row  (nrow),
        .col  (ncol),
        .elem (sel_elem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RD_IDLE;
            rdy_en    <= 1'b0;
            shadow    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
`ifdef MATRIX_READER_TRANSPOSE_EN
            col_major <= 1'b0;
`endif
        end else begin
            rdy_en <= 1'b1;
            if (capture) begin
                shadow  <= load_data;
                out_ovf <= load_ovf;
`ifdef MATRIX_READER_TRANSPOSE_EN
                col_major <= transpose;
`endif
            end
            if (capture || (xfer && !out_last)) begin
                out_data <= sel_elem;
                out_row  <= nrow;
                out_col  <= ncol;
                out_last <= (nrow == LAST) && (ncol == LAST);
            end
            if (capture) begin
                state     <= RD_STREAM;
                out_valid <= 1'b1;
                busy      <= 1'b1;
            end else if (xfer && out_last) begin
                state     <= RD_IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_matrix_result_reader.sv
// Scoreboard bench for matrix_result_reader: reference sequence pushed at load, monitor pops per transfer.
module tb_matrix_result_reader;
    typedef struct packed {
        logic [7:0] data;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
        logic       ovf;
    } exp_t;

    logic         clk = 0, rst = 1, load_valid = 0, load_ovf = 0, out_ready = 0;
    logic [199:0] load_data = '0;
    logic         load_ready, out_valid, out_last, out_ovf, busy;
    logic [7:0]   out_data;
    logic [2:0]   out_row, out_col;
`ifdef MATRIX_READER_TRANSPOSE_EN
    logic         transpose = 0;
`endif

    matrix_result_reader dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_ovf(load_ovf),
`ifdef MATRIX_READER_TRANSPOSE_EN
        .transpose(transpose),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   pop_cnt = 0, first_cyc = 0, last_cyc = 0, hs_cyc = 0;
    int   rmode = 0, ph = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready pattern driver: 0 = always high, 1 = 1,0,0 repeating, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops on every transfer, checks hold stability while stalled.
    initial begin
        logic pv, pr;
        exp_t act, pact, e;
        pv = 0; pr = 0; pact = '0;
        forever begin
            @(negedge clk);
            if (rst) begin pv = 0; continue; end
            act = '{out_data, out_row, out_col, out_last, out_ovf};
            checks++;
            if (busy !== out_valid) begin
                errors++;
                $display("FAIL busy act=%0b req=%0b", busy, out_valid);
            end
            if (pv && !pr) begin
                checks++;
                if (!out_valid || act !== pact) begin
                    errors++;
                    $display("FAIL hold act=%h/%0b req=%h/1", act, out_valid, pact);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_elem act=%h req=none", act);
                end else begin
                    e = sb.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL elem act d=%0d r=%0d c=%0d l=%0b o=%0b req d=%0d r=%0d c=%0d l=%0b o=%0b",
                                 $signed(act.data), act.row, act.col, act.last, act.ovf,
                                 $signed(e.data), e.row, e.col, e.last, e.ovf);
                    end
                end
                if (pop_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                pop_cnt++;
            end
            pv = out_valid; pr = out_ready; pact = act;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Reference model: visiting order follows directly from row/column-major definition.
    task automatic push_expect(input logic [7:0] m[25], input bit ovf, input bit tr);
        exp_t e;
        for (int i = 0; i < 25; i++) begin
            int r, c;
            if (tr) begin c = i / 5; r = i % 5; end
            else    begin r = i / 5; c = i % 5; end
            e.data = m[r*5+c];
            e.row  = 3'(r);
            e.col  = 3'(c);
            e.last = (i == 24);
            e.ovf  = ovf;
            sb.push_back(e);
        end
    endtask

    task automatic load(input logic [7:0] m[25], input bit ovf, input bit tr);
        int t;
        t = 0;
        while (!load_ready && t < 500) begin step(); t++; end
        checks++;
        if (!load_ready) begin
            errors++;
            $display("FAIL load_ready_wait act=0 req=1");
            return;
        end
        for (int k = 0; k < 25; k++) load_data[199-k*8 -: 8] = m[k];
        load_ovf   = ovf;
        load_valid = 1;
`ifdef MATRIX_READER_TRANSPOSE_EN
        transpose = tr;
`endif
        push_expect(m, ovf, tr);
        step();
        load_valid = 0;
        hs_cyc = cyc;
        chk("valid_after_load", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain(input bit scramble);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            if (scramble) load_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step();
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle();
        step();
        chk("idle_vld_busy_rdy", {29'd0, out_valid, busy, load_ready}, 32'b001);
    endtask

    task automatic reset_seq();
        rst = 1;
        step();
        chk("rst_outs", {out_valid, out_data, out_row, out_col, out_last, out_ovf, busy, load_ready}, 32'd0);
        rst = 0;
        chk("rdy_first_cycle", 32'(load_ready), 32'd0);
        step();
        chk("rdy_after", 32'(load_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] m[25], a[25], b[25];
        bit tr;
        for (int k = 0; k < 25; k++) begin m[k] = 8'(k + 1); a[k] = 8'h11; b[k] = 8'hEE; end

        rmode = 0;
        reset_seq();

        // row-major, out_ready high
        pop_cnt = 0;
        load(m, 0, 0);
        wait_drain(0);
        chk("first_latency", 32'(first_cyc), 32'(hs_cyc));
        chk("count_rowmajor", 32'(pop_cnt), 32'd25);
        chk("stream_cycles", 32'(last_cyc - first_cyc), 32'd24);
        check_idle();

        // backpressure plus input isolation
        rmode = 1; ph = 0;
        pop_cnt = 0;
        load(m, 0, 0);
        wait_drain(1);
        chk("count_bp", 32'(pop_cnt), 32'd25);
        check_idle();

        // back-to-back A then B
        rmode = 0;
        step();
        pop_cnt = 0;
        load(a, 1, 0);
        load(b, 0, 0);
        wait_drain(0);
        chk("count_b2b", 32'(pop_cnt), 32'd50);
        chk("b2b_no_gap", 32'(last_cyc - first_cyc), 32'd49);
        check_idle();

        // reset after 10 transfers
        pop_cnt = 0;
        load(m, 1, 0);
        for (int t = 0; t < 100 && pop_cnt < 10; t++) step();
        chk("pre_reset_count", 32'(pop_cnt), 32'd10);
        sb.delete();
        reset_seq();
        pop_cnt = 0;
        load(m, 0, 0);
        wait_drain(0);
        chk("count_after_rst", 32'(pop_cnt), 32'd25);

`ifdef MATRIX_READER_TRANSPOSE_EN
        pop_cnt = 0;
        load(m, 0, 1);
        wait_drain(0);
        chk("count_transpose", 32'(pop_cnt), 32'd25);
`endif

        // random matrices, random backpressure, occasional back-to-back
        rmode = 2;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 25; k++) m[k] = 8'($urandom);
            tr = 0;
`ifdef MATRIX_READER_TRANSPOSE_EN
            tr = 1'($urandom_range(0, 1));
`endif
            load(m, 1'($urandom_range(0, 1)), tr);
            if (it % 2 == 1) begin
                for (int k = 0; k < 25; k++) m[k] = 8'($urandom);
                load(m, 1'($urandom_range(0, 1)), tr);
            end
            wait_drain(1);
        end
        rmode = 0;
        check_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_result_reader.md
# matrix_result_reader

Reads a packed 5x5 signed-byte result matrix, as produced by the matrix multiply unit (200-bit `n_out` plus `ovf`), and streams it out one element per transfer over a valid/ready interface. Each element is tagged with row/column indices and a last flag. The block sits between the coprocessor's arithmetic units and the HPS-facing output path. It is the read-side counterpart of the packed operand buses driven into the arithmetic units.

## Interface
Parameters:
- `N`, default 5: matrix dimension (N x N).
- `W`, default 8: element width in bits, signed two's complement.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: a packed matrix is offered.
- `load_ready` out 1: the reader can accept a matrix.
- `load_data` in N*N*W (200): packed matrix. Element (r,c), k=r*N+c, sits at bits [N*N*W-1-k*W -: W]. Element (0,0) is in the MSBs.
- `load_ovf` in 1: overflow flag accompanying `load_data`.
- `out_valid` out 1: an element is presented.
- `out_ready` in 1: the consumer accepts the element.
- `out_data` out W: element value, signed.
- `out_row` out 3: row index of the element.
- `out_col` out 3: column index of the element.
- `out_last` out 1: high on the final element of the matrix.
- `out_ovf` out 1: captured `load_ovf`, held constant for the whole matrix.
- `busy` out 1: high while in STREAM.

## Operation
- **States:** IDLE and STREAM.
- **IDLE:**
  - `load_ready`=1 and `out_valid`=0.
  - On `load_valid && load_ready`, the block captures `load_data` and `load_ovf` into a shadow register, sets the element counter k=0, and moves to STREAM.
- **STREAM:**
  - `out_valid`=1. `out_data` is element k of the shadow register, `out_row`=k/N, `out_col`=k%N, and `out_last`=(k==N*N-1).
  - On `out_valid && out_ready`, k increments.
  - On the transfer with `out_last`=1, the block returns to IDLE.
- **Back-to-back loads:**
  - `load_ready` is also high in STREAM during the cycle in which the last element transfers (`out_last && out_ready`).
  - If `load_valid` is high in that cycle, the new matrix is captured, k=0, and the block stays in STREAM with no bubble.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, every `out_*` signal stays stable.
- **Input isolation:** `load_data` changes during STREAM have no effect. Only the shadow register is read.
- **Index generation:** row and column are kept as separate counters. Column wraps at N-1 and increments the row. No divider.
- **Overflow:** `out_ovf` reflects the captured flag only. The block does no arithmetic and no saturation.
- **Reset:**
  - Values: state=IDLE, k=0, shadow=0, `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `out_ovf`=0, `busy`=0, `load_ready`=0.
  - `load_ready` goes to 1 in the first cycle after `rst` deasserts.
  - Reset mid-stream abandons the matrix immediately. No partial flush.

## Timing
- **Load to first element:** `out_valid` rises 1 cycle after the load handshake edge.
- **Full matrix:** 25 cycles with `out_ready` held high. Back-to-back matrices: 25 cycles per matrix, with 0 idle cycles between them.
- **Outputs:** all `out_*` signals and `busy` are registered.
- **`load_ready`:** combinational from state, `out_last` and `out_ready`.
- **`out_ready` dependency:** `out_ready` may be deasserted for any number of cycles. Throughput is one element per cycle when it is high.

## Configuration
- **Macro:** `MATRIX_READER_TRANSPOSE_EN`.
- **When defined:** adds input `transpose` (1 bit), sampled at the load handshake.
  - With `transpose`=1, elements stream in column-major order: k visits (0,0),(1,0),...,(4,0),(0,1),...
  - `out_row` and `out_col` still report the true element position.
- **When undefined:** the port is absent and order is always row-major.

## Structure
- **Shared package `matrix_pkg`:** holds constants N=5, W=8, MAT_BITS=200, and IDX_W=3. It also holds the state enum `rd_state_t` (RD_IDLE, RD_STREAM).
- **Sub-module:** one natural sub-module, `matrix_elem_sel`. It is a combinational mux that extracts element (row,col) from the packed 200-bit vector using the MSB-first ordering. The same ordering helper is reusable by the operand writer.

## Test plan
- **Row-major stream, `out_ready`=1:**
  - Stimulus: reset, then load elements 1..25 (byte k = k+1), with `load_ovf`=0.
  - Required response: out_data sequence 1,2,...,25. (row,col) sequence (0,0),(0,1),...,(4,4). `out_last` only on 25. `out_valid` first high exactly 1 cycle after the handshake.
- **Backpressure:**
  - Stimulus: toggle `out_ready` 1,0,0,1,... over the same load.
  - Required response: each element is held stable while stalled. No duplicates and no drops. Total of 25 transfers.
- **Back-to-back:**
  - Stimulus: matrix A (all 0x11, ovf=1), then matrix B (all 0xEE=-18, ovf=0), with B's `load_valid` asserted during A's last transfer.
  - Required response: 50 consecutive transfers with no gap. `out_ovf`=1 for A and 0 for B. `out_data` of B reads -18.
- **Input isolation:** changing `load_data` mid-stream leaves the output sequence unchanged.
- **Reset mid-stream:**
  - Stimulus: assert `rst` after element 10.
  - Required response: next cycle all outputs are 0 and the block is IDLE. The first cycle after reset has `load_ready`=0, then 1. A new load restarts at (0,0).
- **`MATRIX_READER_TRANSPOSE_EN`:**
  - Stimulus: `transpose`=1 with element values 1..25.
  - Required response: sequence 1,6,11,16,21,2,7,... with `out_last` on 25 at (4,4).
